// File: rtl/cache_axi_arbiter.sv
// Shares one AXI master port between the i-cache (reads only) and the d-cache (reads and writes).
// AR/R use round-robin arbitration, AW/W/B pass through, and d-cache reads wait behind writes.
module cache_axi_arbiter #(
  parameter logic [3:0] I_ID = 4'd0,
  parameter logic [3:0] D_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  input  logic        i_arvalid,
  output logic        i_arready,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  output logic        i_rvalid,
  input  logic        i_rready,
  input  logic [31:0] d_araddr,
  input  logic [7:0]  d_arlen,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  output logic        d_rvalid,
  input  logic        d_rready,
  input  logic [31:0] d_awaddr,
  input  logic [7:0]  d_awlen,
  input  logic        d_awvalid,
  output logic        d_awready,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  input  logic        d_wlast,
  input  logic        d_wvalid,
  output logic        d_wready,
  output logic        d_bvalid,
  input  logic        d_bready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {R_IDLE, I_AR, I_R, D_AR, D_R} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_D, W_B} wr_state_t;

  rd_state_t rd_state, rd_next;
  wr_state_t wr_state, wr_next;
  logic      last_d;
  logic      wr_busy;
  logic      d_ok;
  logic      rd_done;
  logic      unused_ok;

  // Only one read is ever outstanding, so the response ID and status carry no routing information.
  assign unused_ok = ^{rid, rresp, bid, bresp};

  assign wr_busy = (wr_state != W_IDLE) | d_awvalid;
  assign d_ok    = d_arvalid & ~wr_busy;
  assign rd_done = ((rd_state == I_R) | (rd_state == D_R)) & rvalid & rready & rlast;

  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign awid    = D_ID;
  assign wid     = D_ID;
  assign i_rdata = rdata;
  assign d_rdata = rdata;
  assign wdata   = d_wdata;
  assign wstrb   = d_wstrb;
  assign wlast   = d_wlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= R_IDLE;
      wr_state <= W_IDLE;
      last_d   <= 1'b1;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
      if (rd_done) last_d <= (rd_state == D_R);
    end
  end

  // Read arbitration: ties go to the side that did not win the previous read.
  always_comb begin
    rd_next   = rd_state;
    arvalid   = 1'b0;
    arid      = I_ID;
    araddr    = '0;
    arlen     = '0;
    i_arready = 1'b0;
    d_arready = 1'b0;
    i_rvalid  = 1'b0;
    i_rlast   = 1'b0;
    d_rvalid  = 1'b0;
    d_rlast   = 1'b0;
    rready    = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (i_arvalid && d_ok) rd_next = last_d ? I_AR : D_AR;
        else if (i_arvalid)    rd_next = I_AR;
        else if (d_ok)         rd_next = D_AR;
      end
      I_AR: begin
        arvalid   = i_arvalid;
        arid      = I_ID;
        araddr    = i_araddr;
        arlen     = i_arlen;
        i_arready = arready;
        if (i_arvalid && arready) rd_next = I_R;
      end
      I_R: begin
        i_rvalid = rvalid;
        i_rlast  = rlast;
        rready   = i_rready;
        if (rvalid && i_rready && rlast) rd_next = R_IDLE;
      end
      D_AR: begin
        arvalid   = d_arvalid;
        arid      = D_ID;
        araddr    = d_araddr;
        arlen     = d_arlen;
        d_arready = arready;
        if (d_arvalid && arready) rd_next = D_R;
      end
      D_R: begin
        d_rvalid = rvalid;
        d_rlast  = rlast;
        rready   = d_rready;
        if (rvalid && d_rready && rlast) rd_next = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  // Write path: each channel is connected only while its phase is active.
  always_comb begin
    wr_next   = wr_state;
    awvalid   = 1'b0;
    awaddr    = '0;
    awlen     = '0;
    d_awready = 1'b0;
    wvalid    = 1'b0;
    d_wready  = 1'b0;
    d_bvalid  = 1'b0;
    bready    = 1'b0;
    case (wr_state)
      W_IDLE: begin
        if (d_awvalid) wr_next = W_AW;
      end
      W_AW: begin
        awvalid   = d_awvalid;
        awaddr    = d_awaddr;
        awlen     = d_awlen;
        d_awready = awready;
        if (d_awvalid && awready) wr_next = W_D;
      end
      W_D: begin
        wvalid   = d_wvalid;
        d_wready = wready;
        if (d_wvalid && wready && d_wlast) wr_next = W_B;
      end
      W_B: begin
        d_bvalid = bvalid;
        bready   = d_bready;
        if (bvalid && d_bready) wr_next = W_IDLE;
      end
      default: wr_next = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Bench for cache_axi_arbiter: cache/slave agents, a transaction-level reference model
// compared every cycle, and directed scenarios with literal expectations.
module tb_cache_axi_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [31:0] i_araddr = '0, d_araddr = '0, d_awaddr = '0, d_wdata = '0, rdata = '0;
  logic [7:0]  i_arlen = '0, d_arlen = '0, d_awlen = '0;
  logic        i_arvalid = 0, i_rready = 1, d_arvalid = 0, d_rready = 1;
  logic        d_awvalid = 0, d_wlast = 0, d_wvalid = 0, d_bready = 1;
  logic [3:0]  d_wstrb = 4'hF, rid = 4'd0, bid = 4'd1;
  logic [1:0]  rresp = 2'b00, bresp = 2'b00;
  logic        arready = 0, rlast = 0, rvalid = 0, awready = 1, wready = 0, bvalid = 0;

  logic        i_arready, i_rlast, i_rvalid, d_arready, d_rlast, d_rvalid;
  logic        d_awready, d_wready, d_bvalid, arvalid, rready, awvalid, wvalid, wlast, bready;
  logic [31:0] i_rdata, d_rdata, araddr, awaddr, wdata;
  logic [3:0]  arid, awid, wid, wstrb;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;

  cache_axi_arbiter #(.I_ID(4'd0), .D_ID(4'd1)) dut (
    .clk(clk), .rst(rst),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
    .d_awaddr(d_awaddr), .d_awlen(d_awlen), .d_awvalid(d_awvalid), .d_awready(d_awready),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wlast(d_wlast), .d_wvalid(d_wvalid),
    .d_wready(d_wready), .d_bvalid(d_bvalid), .d_bready(d_bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  // Reference model: one read record (owner, address sent) and one write record (AW/W done).
  bit m_busy = 0, m_sent = 0, m_who = 0, m_last_d = 1;
  bit m_wact = 0, m_awd = 0, m_wd = 0;
  wire ar_ph = m_busy & ~m_sent;
  wire r_ph  = m_busy & m_sent;
  wire aw_ph = m_wact & ~m_awd;
  wire w_ph  = m_wact & m_awd & ~m_wd;
  wire b_ph  = m_wact & m_wd;
  wire e_arvalid   = ar_ph & (m_who ? d_arvalid : i_arvalid);
  wire e_i_arready = ar_ph & ~m_who & arready;
  wire e_d_arready = ar_ph & m_who & arready;
  wire e_rready    = r_ph & (m_who ? d_rready : i_rready);
  wire e_i_rvalid  = r_ph & ~m_who & rvalid;
  wire e_d_rvalid  = r_ph & m_who & rvalid;
  wire e_awvalid   = aw_ph & d_awvalid;
  wire e_d_awready = aw_ph & awready;
  wire e_wvalid    = w_ph & d_wvalid;
  wire e_d_wready  = w_ph & wready;
  wire e_d_bvalid  = b_ph & bvalid;
  wire e_bready    = b_ph & d_bready;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 0; m_sent <= 0; m_last_d <= 1;
      m_wact <= 0; m_awd <= 0; m_wd <= 0;
    end else begin
      if (!m_busy) begin
        if (i_arvalid || (d_arvalid && !(m_wact || d_awvalid))) begin
          m_busy <= 1; m_sent <= 0;
          if (i_arvalid && d_arvalid && !(m_wact || d_awvalid)) m_who <= ~m_last_d;
          else m_who <= ~i_arvalid;
        end
      end else if (!m_sent) begin
        if (e_arvalid && arready) m_sent <= 1;
      end else if (rvalid && e_rready && rlast) begin
        m_busy <= 0; m_last_d <= m_who;
      end
      if (!m_wact) begin
        if (d_awvalid) m_wact <= 1;
      end else if (aw_ph) begin
        if (d_awvalid && awready) m_awd <= 1;
      end else if (w_ph) begin
        if (d_wvalid && wready && d_wlast) m_wd <= 1;
      end else if (bvalid && d_bready) begin
        m_wact <= 0; m_awd <= 0; m_wd <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("arvalid", arvalid, e_arvalid);
      if (ar_ph) begin
        chk("arid", arid, m_who ? 32'd1 : 32'd0);
        chk("araddr", araddr, m_who ? d_araddr : i_araddr);
        chk("arlen", arlen, m_who ? d_arlen : i_arlen);
      end
      chk("i_arready", i_arready, e_i_arready);
      chk("d_arready", d_arready, e_d_arready);
      chk("rready", rready, e_rready);
      chk("i_rvalid", i_rvalid, e_i_rvalid);
      chk("d_rvalid", d_rvalid, e_d_rvalid);
      if (e_i_rvalid) begin
        chk("i_rlast", i_rlast, rlast);
        chk("i_rdata", i_rdata, rdata);
      end
      if (e_d_rvalid) begin
        chk("d_rlast", d_rlast, rlast);
        chk("d_rdata", d_rdata, rdata);
      end
      chk("awvalid", awvalid, e_awvalid);
      chk("d_awready", d_awready, e_d_awready);
      if (aw_ph) begin
        chk("awaddr", awaddr, d_awaddr);
        chk("awlen", awlen, d_awlen);
      end
      chk("wvalid", wvalid, e_wvalid);
      chk("d_wready", d_wready, e_d_wready);
      if (e_wvalid) begin
        chk("wdata", wdata, d_wdata);
        chk("wstrb", wstrb, d_wstrb);
        chk("wlast", wlast, d_wlast);
      end
      chk("d_bvalid", d_bvalid, e_d_bvalid);
      chk("bready", bready, e_bready);
      chk("ar_consts", {arsize, arburst}, {3'b010, 2'b01});
      chk("aw_consts", {awsize, awburst, awid, wid}, {3'b010, 2'b01, 4'd1, 4'd1});
    end
  end

  // Cache requesters, AXI slave and monitors: sample at negedge, drive 1 time unit after posedge.
  int i_todo = 0, d_todo = 0, w_stage = 0, w_beat = 0, ar_delay = 2, ar_cnt = 0;
  int r_idx = 0, r_len = 0, cyc = 0, i_arv_cycles = 0, d_arv_first = -1, b_cycle = -1;
  int wbeats_d = 0, bcount = 0;
  bit w_go = 0, w_toggle = 0, wready_knob = 1, d_rvalid_seen = 0, ar_wd_flag = 0;
  logic [31:0] r_base = '0;
  logic [31:0] i_rx[$], d_rx[$];
  logic [3:0]  grants[$];

  initial begin
    bit s_rst, s_i_ar, s_d_ar, s_aw, s_w, s_b, s_mar, s_mr, s_mrlast, s_mw, s_mwlast, s_mb;
    bit s_arvalid, s_wvalid;
    logic [3:0] s_arid, s_wid;
    logic [31:0] s_araddr;
    logic [7:0] s_arlen;
    forever begin
      @(negedge clk);
      s_rst = rst;
      s_i_ar = i_arvalid & i_arready;  s_d_ar = d_arvalid & d_arready;
      s_aw = d_awvalid & d_awready;    s_w = d_wvalid & d_wready;  s_b = d_bvalid & d_bready;
      s_mar = arvalid & arready;       s_mr = rvalid & rready;     s_mrlast = rlast;
      s_mw = wvalid & wready;          s_mwlast = wlast;           s_mb = bvalid & bready;
      s_arvalid = arvalid; s_arid = arid; s_araddr = araddr; s_arlen = arlen;
      s_wvalid = wvalid;   s_wid = wid;
      if (i_rvalid && i_rready) i_rx.push_back(i_rdata);
      if (d_rvalid && d_rready) d_rx.push_back(d_rdata);
      if (d_rvalid) d_rvalid_seen = 1;
      @(posedge clk);
      #1;
      if (s_mar) begin grants.push_back(s_arid); ar_wd_flag = s_wvalid; end
      if (s_arvalid && s_arid == 4'd0 && s_araddr == 32'h1FC0_0000) i_arv_cycles++;
      if (s_arvalid && s_arid == 4'd1 && d_arv_first < 0) d_arv_first = cyc;
      if (s_mb) begin b_cycle = cyc; bcount++; end
      if (s_mw && s_wid == 4'd1) wbeats_d++;
      cyc++;
      if (s_rst) begin
        i_todo = 0; d_todo = 0; i_arvalid = 0; d_arvalid = 0;
        w_stage = 0; w_go = 0; d_awvalid = 0; d_wvalid = 0; d_wlast = 0;
        rvalid = 0; rlast = 0; bvalid = 0; ar_cnt = 0; arready = (ar_delay == 0);
      end else begin
        if (s_i_ar) begin i_todo--; i_araddr += 32'h40; end
        if (s_d_ar) begin d_todo--; d_araddr += 32'h40; end
        i_arvalid = (i_todo != 0);
        d_arvalid = (d_todo != 0);
        case (w_stage)
          0: if (w_go) begin d_awvalid = 1; w_stage = 1; end
          1: if (s_aw) begin
            d_awvalid = 0; w_stage = 2; w_beat = 0;
            d_wvalid = 1; d_wdata = 32'h5A00_0000; d_wlast = (d_awlen == 8'd0);
          end
          2: if (s_w) begin
            if (d_wlast) begin d_wvalid = 0; d_wlast = 0; w_stage = 3; end
            else begin
              w_beat++;
              d_wdata = 32'h5A00_0000 + w_beat;
              d_wlast = (w_beat == int'(d_awlen));
            end
          end
          default: if (s_b) begin w_stage = 0; w_go = 0; end
        endcase
        if (s_mb) bvalid = 0;
        if (s_mw && s_mwlast) bvalid = 1;
        if (s_mr) begin
          if (s_mrlast) begin rvalid = 0; rlast = 0; end
          else begin r_idx++; rdata = r_base + r_idx; rlast = (r_idx == r_len); end
        end
        if (s_mar) begin
          r_len = int'(s_arlen); r_idx = 0;
          r_base = (s_arid == 4'd0) ? 32'hCAFE_0000 : 32'hD00D_0000;
          rvalid = 1; rdata = r_base; rlast = (s_arlen == 8'd0);
          ar_cnt = 0; arready = (ar_delay == 0);
        end else if (s_arvalid) begin
          ar_cnt++; arready = (ar_cnt >= ar_delay);
        end
        wready = w_toggle ? ~wready : wready_knob;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    step(3);
    rst = 0;
    cmp_en = 1;
    chk("reset_handshakes", {arvalid, rready, awvalid, wvalid, bready, i_arready, d_arready,
        i_rvalid, d_rvalid, d_awready, d_wready, d_bvalid}, 32'd0);
    chk("reset_araddr", araddr, 32'd0);
    chk("reset_awaddr", awaddr, 32'd0);

    // Single i-read with a 2-cycle AR stall.
    i_araddr = 32'h1FC0_0000; i_arlen = 8'd0; i_todo = 1;
    for (int k = 0; k < 100 && i_rx.size() < 1; k++) step(1);
    chk("t1_done", i_rx.size(), 32'd1);
    chk("t1_arvalid_cycles", i_arv_cycles, 32'd3);
    if (grants.size() > 0) chk("t1_arid", grants[0], 32'd0);
    if (i_rx.size() > 0) chk("t1_rdata", i_rx[0], 32'hCAFE_0000);
    chk("t1_d_rvalid_quiet", d_rvalid_seen, 32'd0);

    // Continuous requests from both caches after a fresh reset.
    rst = 1; step(2); rst = 0;
    grants.delete(); i_rx.delete(); d_rx.delete();
    ar_delay = 0;
    i_arlen = 8'd1; d_arlen = 8'd0; d_araddr = 32'h8000_0000;
    i_todo = 2; d_todo = 2;
    for (int k = 0; k < 200 && grants.size() < 4; k++) step(1);
    for (int k = 0; k < 100 && d_rx.size() < 2; k++) step(1);
    chk("t2_grants", grants.size(), 32'd4);
    if (grants.size() >= 4) chk("t2_order", {grants[0], grants[1], grants[2], grants[3]}, 32'h0101);
    chk("t2_i_beats", i_rx.size(), 32'd4);
    step(2);

    // d-write len 3 with toggling wready; a d-read requested in the same cycle must wait.
    w_toggle = 1; d_awaddr = 32'h8000_0100; d_awlen = 8'd3;
    d_arlen = 8'd0; d_araddr = 32'h8000_0200;
    wbeats_d = 0; d_arv_first = -1; b_cycle = -1; d_rx.delete(); grants.delete();
    w_go = 1; d_todo = 1;
    for (int k = 0; k < 200 && d_rx.size() < 1; k++) step(1);
    chk("t3_done", d_rx.size(), 32'd1);
    chk("t3_wbeats", wbeats_d, 32'd4);
    chk("t3_read_after_b", d_arv_first - b_cycle, 32'd2);
    if (d_rx.size() > 0) chk("t3_rdata", d_rx[0], 32'hD00D_0000);
    step(2);

    // i-read proceeds while a write is parked in its data phase.
    w_toggle = 0; wready_knob = 0; d_awlen = 8'd1; nb = bcount;
    grants.delete(); i_rx.delete();
    w_go = 1;
    for (int k = 0; k < 50 && !wvalid; k++) step(1);
    chk("t4_in_wd", wvalid, 32'd1);
    i_araddr = 32'h1FC0_0040; i_arlen = 8'd1; i_todo = 1;
    for (int k = 0; k < 50 && grants.size() < 1; k++) step(1);
    chk("t4_ar_during_wd", {ar_wd_flag, grants.size() > 0 ? grants[0] : 4'hF}, {1'b1, 4'd0});
    wready_knob = 1;
    for (int k = 0; k < 100 && (w_go || i_rx.size() < 2); k++) step(1);
    chk("t4_b_done", bcount - nb, 32'd1);
    if (i_rx.size() >= 2) chk("t4_i_data", i_rx[1], 32'hCAFE_0001);
    else chk("t4_i_beats", i_rx.size(), 32'd2);
    step(2);

    // Reset during beat 2 of a len-3 d-read, then an i-read.
    d_arlen = 8'd3; d_araddr = 32'h8000_0300; d_todo = 1;
    for (int k = 0; k < 50 && !(rvalid && r_idx == 1); k++) step(1);
    chk("t5_beat2", {rvalid, d_rvalid}, 32'd3);
    rst = 1;
    step(1);
    chk("t5_reset_handshakes", {arvalid, rready, awvalid, wvalid, bready, i_arready, d_arready,
        i_rvalid, d_rvalid, d_awready, d_wready, d_bvalid}, 32'd0);
    rst = 0;
    i_rx.delete();
    i_araddr = 32'h1FC0_0080; i_arlen = 8'd0; i_todo = 1;
    for (int k = 0; k < 50 && i_rx.size() < 1; k++) step(1);
    chk("t5_i_read", i_rx.size(), 32'd1);
    if (i_rx.size() > 0) chk("t5_rdata", i_rx[0], 32'hCAFE_0000);
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_axi_arbiter.md
# cache_axi_arbiter

Shares the single AXI master port of the CPU between the instruction cache (read-only) and the data cache (read and write). It multiplexes the AR/R channels between the two cache read requesters with round-robin arbitration, passes the data cache's AW/W/B channels through, and orders data reads behind outstanding writes. It sits between `i_cache`/`d_cache` and the top-level AXI interface.

## Interface
Parameters:
- `I_ID`, 4'd0: ARID driven for instruction-cache reads.
- `D_ID`, 4'd1: ARID/AWID driven for data-cache reads and writes.

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock.
- `rst`  in  1  reset; synchronous, active-high.
- `i_araddr`/`i_arlen`/`i_arvalid`  in  32/8/1  i-cache read request.
- `i_arready`  out  1  i-cache AR accept.
- `i_rdata`  out  32  read data to i-cache.
- `i_rlast`/`i_rvalid`  out  1/1  read beat to i-cache.
- `i_rready`  in  1  i-cache accepts beat.
- `d_araddr`/`d_arlen`/`d_arvalid`/`d_arready`/`d_rdata`/`d_rlast`/`d_rvalid`/`d_rready`: the same read bundle for the d-cache.
- `d_awaddr`/`d_awlen`/`d_awvalid`  in  32/8/1  d-cache write address.
- `d_awready`  out  1  AW accept.
- `d_wdata`/`d_wstrb`/`d_wlast`/`d_wvalid`  in  32/4/1/1  write beat.
- `d_wready`  out  1  write-beat accept.
- `d_bvalid`  out  1  write response valid.
- `d_bready`  in  1  write response accept.
- `arid`/`araddr`/`arlen`/`arsize`/`arburst`/`arvalid`  out  4/32/8/3/2/1  master AR.
- `arready`  in  1  master AR accept.
- `rid`/`rdata`/`rresp`/`rlast`/`rvalid`  in  4/32/2/1/1  master R.
- `rready`  out  1  master R accept.
- `awid`/`awaddr`/`awlen`/`awsize`/`awburst`/`awvalid`  out  4/32/8/3/2/1  master AW.
- `awready`  in  1  master AW accept.
- `wid`/`wdata`/`wstrb`/`wlast`/`wvalid`  out  4/32/4/1/1  master W.
- `wready`  in  1  master W accept.
- `bid`/`bresp`/`bvalid`  in  4/2/1  master B.
- `bready`  out  1  master B accept.

## Operation
- Constant outputs: `arsize`=`awsize`=3'b010; `arburst`=`awburst`=2'b01 (INCR); `awid`=`wid`=`D_ID`.
- Read FSM states: R_IDLE, I_AR, I_R, D_AR, D_R.
  - R_IDLE: `d_ok` = `d_arvalid` & ~`wr_busy`.
    - If `i_arvalid` & `d_ok`, go to the side that did not win last (`last_d`): `last_d`=1 → I_AR, else D_AR.
    - Otherwise go to whichever side is requesting; stay in R_IDLE if neither.
  - I_AR/D_AR: master AR fields come from the granted side; `arvalid` = granted arvalid; `arid` = `I_ID`/`D_ID`; granted `*_arready` = `arready`. On `arvalid`&`arready` go to I_R/D_R.
  - I_R/D_R: master R is routed to the granted side (`*_rvalid`, `*_rlast`, `*_rdata`); `rready` = granted `*_rready`. On `rvalid`&`rready`&`rlast` go to R_IDLE and set `last_d` to (state==D_R).
  - The non-granted side always sees `*_arready`=0 and `*_rvalid`=0. `rid` and `rresp` are ignored; only one read is outstanding at a time.
- Write FSM states: W_IDLE, W_AW, W_D, W_B.
  - W_IDLE → W_AW when `d_awvalid`.
  - W_AW: pass AW through; on `awvalid`&`awready` → W_D.
  - W_D: pass W through; on `wvalid`&`wready`&`wlast` → W_B.
  - W_B: pass B through; on `bvalid`&`bready` → W_IDLE.
  - Master AW/W/B handshakes are gated to the matching state; all are 0 elsewhere.
- `wr_busy` = (write state ≠ W_IDLE) | `d_awvalid`. It blocks only new d-cache read grants; an in-flight d-cache read completes normally; i-cache reads are never blocked.
- Reads and writes proceed concurrently on independent channels.

## Timing
- Reset: both FSMs go to IDLE; `last_d`=1, so the i-cache wins the first tie. Every valid/ready output is 0; `araddr`/`awaddr`=0.
- Grant is registered: a request seen in R_IDLE at cycle n gives `arvalid`=1 at cycle n+1.
- The cycle after a read's `rlast` handshake is always R_IDLE; back-to-back reads are spaced by at least one cycle. A write beginning in W_IDLE reaches `awvalid` one cycle later.
- Requesters hold AR/AW fields stable until their ready (AXI rule); the arbiter does not latch addresses.
- Same-cycle `d_awvalid` and `d_arvalid` in R_IDLE: the write wins and the read waits until W_B completes (`bvalid`&`bready`) plus one cycle.
- `rst` mid-burst forces both FSMs to IDLE on the next edge regardless of handshakes in progress.

## Test plan
- Single i-read (0x1FC0_0000, len 0) with `arready` delayed 2 cycles: `arid`=0, `arvalid` held 3 cycles, `i_rdata` = master `rdata`; `d_rvalid` stays 0 throughout.
- Both caches request continuously: grants alternate I, D, I, D…; the first grant after reset goes to the i-cache.
- d-cache write of len 3 with `wready` toggling: 4 beats pass through with `wid`=1; then d-read issued after the `bvalid` handshake and not before.
- d-write outstanding while the i-cache reads: the i-read's AR is issued while the write is in W_D; the two complete independently.
- `rst` asserted during beat 2 of a len-3 d-read: next cycle all valid/ready outputs are 0 and both FSMs are IDLE; a subsequent i-read succeeds.
